// File: rtl/clock_div_pair.sv
// Two programmable 50%-duty clock dividers with glitch-free divisor updates.
// Optional CLKDIV_PHASE_SYNC_EN: divisor updates and enable re-start phase-align both channels.
module clock_div_pair #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RST_DIV = 1
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_x,
  input  logic [WIDTH-1:0] div_y,
  output logic             load_ready,
  output logic             x_out,
  output logic             y_out,
  output logic             x_rise,
  output logic             y_rise
);

  localparam logic [WIDTH-1:0] RstDiv = WIDTH'(RST_DIV);

  // Index 0 is channel x, index 1 is channel y.
  logic [1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0][WIDTH-1:0] act_q, act_d;
  logic [1:0][WIDTH-1:0] shd_q, shd_d;
  logic [1:0]            out_q, out_d;
  logic [1:0]            rise_q, rise_d;
  logic [1:0]            pend_q, pend_d;
  logic [1:0]            run, tog;
  logic                  idle;
`ifdef CLKDIV_PHASE_SYNC_EN
  logic                  en_q;
  logic                  restart;
`endif

  assign load_ready = ~|pend_q;
  // A high channel keeps running after en drops so no high pulse is shortened.
  assign run        = {2{en}} | out_q;
  assign idle       = ~en & (out_q == 2'b00);

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    out_d  = out_q;
    pend_d = pend_q;
    rise_d = '0;
    tog    = '0;
    for (int c = 0; c < 2; c++) begin
      tog[c] = run[c] && (cnt_q[c] == act_q[c]);
      if (tog[c]) begin
        out_d[c]  = ~out_q[c];
        cnt_d[c]  = '0;
        rise_d[c] = ~out_q[c];
      end else if (run[c]) begin
        cnt_d[c] = cnt_q[c] + WIDTH'(1);
      end
      // Uses pend_q, so a load landing on a toggle waits for the following one.
      if (pend_q[c] && (tog[c] || idle)) begin
        act_d[c]  = shd_q[c];
        pend_d[c] = 1'b0;
        // A stopped channel starts its new divisor from a fresh half-period.
        if (idle) cnt_d[c] = '0;
      end
    end
`ifdef CLKDIV_PHASE_SYNC_EN
    restart = ((|pend_q) && ((|tog) || idle)) || (en && !en_q);
    if (restart) begin
      cnt_d  = '0;
      out_d  = '0;
      rise_d = '0;
      if (|pend_q) begin
        act_d  = shd_q;
        pend_d = '0;
      end
    end
`endif
    if (load && load_ready) begin
      shd_d  = {div_y, div_x};
      pend_d = 2'b11;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      cnt_q  <= '0;
      act_q  <= {RstDiv, RstDiv};
      shd_q  <= {RstDiv, RstDiv};
      out_q  <= '0;
      rise_q <= '0;
      pend_q <= '0;
`ifdef CLKDIV_PHASE_SYNC_EN
      en_q   <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      pend_q <= pend_d;
`ifdef CLKDIV_PHASE_SYNC_EN
      en_q   <= en;
`endif
    end
  end

  assign x_out  = out_q[0];
  assign y_out  = out_q[1];
  assign x_rise = rise_q[0];
  assign y_rise = rise_q[1];

endmodule

// File: tb/tb_clock_div_pair.sv
// Randomised self-checking bench for clock_div_pair against a countdown-based model.
module tb_clock_div_pair;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned RST_DIV = 1;

  logic             CLK = 1'b0;
  logic             ASYNCRESETN;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] div_x;
  logic [WIDTH-1:0] div_y;
  logic             load_ready;
  logic             x_out;
  logic             y_out;
  logic             x_rise;
  logic             y_rise;

  int n_checks = 0;
  int n_errors = 0;

  clock_div_pair #(
    .WIDTH  (WIDTH),
    .RST_DIV(RST_DIV)
  ) dut (
    .CLK        (CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .en         (en),
    .load       (load),
    .div_x      (div_x),
    .div_y      (div_y),
    .load_ready (load_ready),
    .x_out      (x_out),
    .y_out      (y_out),
    .x_rise     (x_rise),
    .y_rise     (y_rise)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel counts down the cycles left in its half-period.
  int       m_rem[2];
  int       m_div[2];
  int       m_shd[2];
  bit [1:0] m_out;
  bit [1:0] m_rise;
  bit [1:0] m_pend;
  bit       m_en_prev;

  always @(posedge CLK or negedge ASYNCRESETN) begin : model
    bit [1:0] prev_out, old_pend, toggled;
    bit       stopped;
    if (!ASYNCRESETN) begin
      for (int c = 0; c < 2; c++) begin
        m_rem[c] = RST_DIV;
        m_div[c] = RST_DIV;
        m_shd[c] = RST_DIV;
      end
      m_out     = '0;
      m_rise    = '0;
      m_pend    = '0;
      m_en_prev = 1'b0;
    end else begin
      prev_out = m_out;
      old_pend = m_pend;
      toggled  = '0;
      stopped  = !en && (m_out == 2'b00);
      for (int c = 0; c < 2; c++) begin
        if (en || m_out[c]) begin
          if (m_rem[c] == 0) begin
            m_out[c]   = !m_out[c];
            toggled[c] = 1'b1;
            m_rem[c]   = m_div[c];
          end else begin
            m_rem[c]--;
          end
        end
        if (old_pend[c] && (toggled[c] || stopped)) begin
          m_div[c]  = m_shd[c];
          m_rem[c]  = m_shd[c];
          m_pend[c] = 1'b0;
        end
      end
`ifdef CLKDIV_PHASE_SYNC_EN
      if ((old_pend != 0 && (toggled != 0 || stopped)) || (en && !m_en_prev)) begin
        for (int c = 0; c < 2; c++) begin
          if (old_pend != 0) m_div[c] = m_shd[c];
          m_rem[c] = m_div[c];
        end
        m_pend = '0;
        m_out  = '0;
      end
`endif
      m_en_prev = en;
      if (load && old_pend == 0) begin
        m_shd[0] = int'(div_x);
        m_shd[1] = int'(div_y);
        m_pend   = 2'b11;
      end
      m_rise = m_out & ~prev_out;
    end
  end

  always @(posedge CLK) begin
    #1;
    if (ASYNCRESETN) begin
      chk("x_out", int'(x_out), int'(m_out[0]));
      chk("y_out", int'(y_out), int'(m_out[1]));
      chk("x_rise", int'(x_rise), int'(m_rise[0]));
      chk("y_rise", int'(y_rise), int'(m_rise[1]));
      chk("load_ready", int'(load_ready), int'(m_pend == 0));
    end
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit rise_of(input bit ch);
    return ch ? y_rise : x_rise;
  endfunction

  // Cycles between two consecutive rises of a channel; -1 if none within budget.
  task automatic rise_gap(input bit ch, output int gap);
    int t0;
    gap = -1;
    t0  = -1;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (rise_of(ch)) begin
        if (t0 < 0) t0 = i;
        else begin
          gap = i - t0;
          break;
        end
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!load_ready && n < 200) begin
      cycle();
      n++;
    end
    chk(name, int'(load_ready), 1);
  endtask

  task automatic do_load(input int dx, input int dy);
    load  = 1'b1;
    div_x = WIDTH'(dx);
    div_y = WIDTH'(dy);
    cycle();
    load  = 1'b0;
  endtask

  initial begin
    int g, hi, n;
    ASYNCRESETN = 1'b0;
    en          = 1'b0;
    load        = 1'b0;
    div_x       = '0;
    div_y       = '0;
    repeat (3) cycle();
    chk("rst_x_out", int'(x_out), 0);
    chk("rst_y_out", int'(y_out), 0);
    chk("rst_x_rise", int'(x_rise), 0);
    chk("rst_y_rise", int'(y_rise), 0);
    chk("rst_load_ready", int'(load_ready), 1);
    ASYNCRESETN = 1'b1;
    en          = 1'b1;

    // Reset divisor gives period 4 on both channels; rise pulse one cycle wide.
    rise_gap(1'b0, g);
    chk("x_period_rst", g, 4);
    rise_gap(1'b1, g);
    chk("y_period_rst", g, 4);
    n = 0;
    while (!x_rise && n < 50) begin
      cycle();
      n++;
    end
    cycle();
    chk("x_rise_width", int'(x_rise), 0);
    chk("x_high_after_rise", int'(x_out), 1);

    // Load, then a second load while busy which must be ignored.
    do_load(0, 3);
    chk("busy_after_load", int'(load_ready), 0);
    do_load(7, 7);
    wait_ready("ready_after_load1");
    rise_gap(1'b0, g);
    chk("x_period_div0", g, 2);
    rise_gap(1'b1, g);
    chk("y_period_div3", g, 8);

    // Dropping en while x is high must not shorten its high phase.
    do_load(3, 1);
    wait_ready("ready_after_load2");
    n = 0;
    while (!x_rise && n < 50) begin
      cycle();
      n++;
    end
    en = 1'b0;
    hi = 1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (x_out) hi++;
      else break;
    end
    chk("x_high_len_en_off", hi, 4);
    repeat (6) cycle();
    chk("x_hold_low", int'(x_out), 0);
    chk("y_hold_low", int'(y_out), 0);
    en = 1'b1;

    for (int i = 0; i < 600; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      load  = ($urandom_range(0, 5) == 0);
      div_x = WIDTH'($urandom_range(0, 5));
      div_y = WIDTH'($urandom_range(0, 5));
      cycle();
    end
    load = 1'b0;
    en   = 1'b1;

    // Asynchronous reset mid-period discards a pending load.
    wait_ready("ready_before_rst");
    repeat (3) cycle();
    do_load(4, 6);
    #3;
    ASYNCRESETN = 1'b0;
    #1;
    chk("async_rst_x_out", int'(x_out), 0);
    chk("async_rst_y_out", int'(y_out), 0);
    chk("async_rst_ready", int'(load_ready), 1);
    cycle();
    ASYNCRESETN = 1'b1;
    rise_gap(1'b0, g);
    chk("x_period_after_rst", g, 4);
    rise_gap(1'b1, g);
    chk("y_period_after_rst", g, 4);

`ifdef CLKDIV_PHASE_SYNC_EN
    begin
      int kx, ky;
      do_load(1, 2);
      wait_ready("ready_sync");
      kx = -1;
      ky = -1;
      for (int k = 1; k <= 20; k++) begin
        cycle();
        if (x_rise && kx < 0) kx = k;
        if (y_rise && ky < 0) ky = k;
      end
      chk("sync_first_x_rise", kx, 2);
      chk("sync_first_y_rise", ky, 3);
    end
`endif

    repeat (2) cycle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
